// File: rtl/pipe_pal_pkg.sv
// Shared types and constants for the pipe_pal register-slice chain.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pal_pkg;

    // Default payload width for the chain and its slices.
    localparam int W_DATA_DEF = 32;

    // Per-slice occupancy: no word, main entry only, main + skid entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } slice_state_e;

    // Width needed to count 0 .. 2*n_stages held words.
    function automatic int cnt_width(input int n_stages);
        return $clog2(2 * n_stages + 1);
    endfunction

endpackage

// File: rtl/pipe_pal_skid.sv
// One valid/ready register slice with a 2-entry (main + skid) buffer.
// Latency: 1 cycle from input transfer to o_valid when the output is not stalled.
// Backpressure: o_ready is a register (skid empty); it never depends on i_ready in the same cycle.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               synchronous discard of both entries
//   i_valid/o_ready/i_data   upstream side
//   o_valid/i_ready/o_data   downstream side (o_data = main entry)
module pipe_pal_skid
    import pipe_pal_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_DATA-1:0] o_data
);

    slice_state_e      state_q, state_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic [W_DATA-1:0] main_q, main_d;
    logic [W_DATA-1:0] skid_q, skid_d;
    logic              push;
    logic              pop;

    assign push = i_valid && rdy_q;
    assign pop  = vld_q && i_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            // Data registers keep their contents so o_data still shows the
            // last word; only occupancy is cleared. A same-cycle push is lost.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = i_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = i_data;
                    end else if (push) begin
                        // Downstream stalled: park the new word in the skid.
                        skid_d  = i_data;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // rdy_q is low here, so no push can arrive.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // Ready and valid are registered copies of the next occupancy.
        rdy_d = (state_d != ST_FULL);
        vld_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b0;       // rises on the first cycle out of reset
            vld_q   <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign o_ready = rdy_q;
    assign o_valid = vld_q;
    assign o_data  = main_q;

endmodule

// File: rtl/pipe_pal_chain.sv
// Chain of N_STAGES skid-buffered register slices for timing isolation on long routes.
// Latency: N_STAGES cycles from input transfer to o_valid when unstalled; 1 word/cycle throughput.
// Backpressure: holds up to 2*N_STAGES words; o_ready is registered and drops only when every skid is full.
//
// Optional feature macro: PIPE_PAL_OCC_EN adds the o_count occupancy output.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               synchronous discard of all held words
//   i_valid/o_ready/i_data   upstream side (o_ready from slice 0)
//   o_valid/i_ready/o_data   downstream side (from the last slice)
//   o_count               words held in the chain (PIPE_PAL_OCC_EN only)
module pipe_pal_chain
    import pipe_pal_pkg::*;
#(
    parameter int W_DATA   = W_DATA_DEF,
    parameter int N_STAGES = 2
`ifdef PIPE_PAL_OCC_EN
    ,
    localparam int W_CNT   = cnt_width(N_STAGES)
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [W_DATA-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W_DATA-1:0] o_data
`ifdef PIPE_PAL_OCC_EN
    ,
    output logic [W_CNT-1:0]  o_count
`endif
);

    // Boundary k sits in front of slice k; boundary N_STAGES is the chain output.
    logic [N_STAGES:0] vld;
    logic [N_STAGES:0] rdy;
    logic [W_DATA-1:0] dat [N_STAGES+1];

    assign vld[0]        = i_valid;
    assign dat[0]        = i_data;
    assign rdy[N_STAGES] = i_ready;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_slice
        pipe_pal_skid #(
            .W_DATA (W_DATA)
        ) u_slice (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_flush (i_flush),
            .i_valid (vld[k]),
            .o_ready (rdy[k]),
            .i_data  (dat[k]),
            .o_valid (vld[k+1]),
            .i_ready (rdy[k+1]),
            .o_data  (dat[k+1])
        );
    end

    assign o_ready = rdy[0];
    assign o_valid = vld[N_STAGES];
    assign o_data  = dat[N_STAGES];

`ifdef PIPE_PAL_OCC_EN
    // Occupancy tracks chain-boundary transfers only; inter-slice moves
    // do not change the total number of words held.
    logic [W_CNT-1:0] cnt_q, cnt_d;
    logic             push_in;
    logic             pop_out;

    assign push_in = i_valid && rdy[0];
    assign pop_out = vld[N_STAGES] && i_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (i_flush) begin
            cnt_d = '0;
        end else if (push_in && !pop_out) begin
            cnt_d = cnt_q + W_CNT'(1);
        end else if (pop_out && !push_in) begin
            cnt_d = cnt_q - W_CNT'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_pal_chain.sv
// Directed bench for pipe_pal_chain: a 3-stage instance for streaming latency
// and a 2-stage instance for reset, backpressure, flush and a random-stall run.
module tb_pipe_pal_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_flush, a_valid, a_ready;
    logic [31:0] a_data;
    logic        a_o_ready, a_o_valid;
    logic [31:0] a_o_data;

    logic        b_flush, b_valid, b_ready;
    logic [31:0] b_data;
    logic        b_o_ready, b_o_valid;
    logic [31:0] b_o_data;

`ifdef PIPE_PAL_OCC_EN
    logic [2:0]  a_count;
    logic [2:0]  b_count;
`endif

    pipe_pal_chain #(.W_DATA(32), .N_STAGES(3)) u_dut_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (a_flush),
        .i_valid (a_valid),
        .o_ready (a_o_ready),
        .i_data  (a_data),
        .o_valid (a_o_valid),
        .i_ready (a_ready),
        .o_data  (a_o_data)
`ifdef PIPE_PAL_OCC_EN
        ,
        .o_count (a_count)
`endif
    );

    pipe_pal_chain #(.W_DATA(32), .N_STAGES(2)) u_dut_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (b_flush),
        .i_valid (b_valid),
        .o_ready (b_o_ready),
        .i_data  (b_data),
        .o_valid (b_o_valid),
        .i_ready (b_ready),
        .o_data  (b_o_data)
`ifdef PIPE_PAL_OCC_EN
        ,
        .o_count (b_count)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_w;
    logic        prev_stall;
    logic [31:0] prev_dat;
    int          acc;

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_valid = 1'b0; a_data = '0; a_ready = 1'b1;
        b_flush = 1'b0; b_valid = 1'b1; b_data = 32'hDEAD_BEEF; b_ready = 1'b1;

        // ---- reset held 3 cycles with a word offered
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", 32'(b_o_valid), 32'd0);
            check("rst_ready", 32'(b_o_ready), 32'd0);
            check("rst_data", b_o_data, 32'd0);
`ifdef PIPE_PAL_OCC_EN
            check("rst_count", 32'(b_count), 32'd0);
`endif
        end
        rst = 1'b0;
        tick();
        check("rel_ready_b", 32'(b_o_ready), 32'd1);
        check("rel_ready_a", 32'(a_o_ready), 32'd1);
        check("rel_valid", 32'(b_o_valid), 32'd0);
        b_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rel_no_word", 32'(b_o_valid), 32'd0);
        end

        // ---- streaming through 3 stages: word c+1 pushed before edge c,
        //      visible at the falling edge 3 cycles later
        for (int c = 0; c < 19; c++) begin
            check("str_ready", 32'(a_o_ready), 32'd1);
            check("str_valid", 32'(a_o_valid), 32'(c >= 3));
            if (c >= 3) check("str_data", a_o_data, 32'(c - 2));
            if (c < 16) begin
                a_valid = 1'b1;
                a_data  = 32'(c + 1);
            end else begin
                a_valid = 1'b0;
            end
            tick();
        end
        check("str_drained", 32'(a_o_valid), 32'd0);

        // ---- backpressure on 2 stages: capacity 4
        b_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            b_valid = 1'b1;
            b_data  = 32'h100 + 32'(acc);
            if (b_o_ready) acc++;
            tick();
        end
        b_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(b_o_ready), 32'd0);
        check("bp_valid", 32'(b_o_valid), 32'd1);
        check("bp_head", b_o_data, 32'h100);
`ifdef PIPE_PAL_OCC_EN
        check("bp_count", 32'(b_count), 32'd4);
`endif
        tick();
        check("bp_hold_ready", 32'(b_o_ready), 32'd0);
        check("bp_hold_data", b_o_data, 32'h100);
`ifdef PIPE_PAL_OCC_EN
        check("bp_hold_count", 32'(b_count), 32'd4);
`endif
        b_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bp_out_valid", 32'(b_o_valid), 32'd1);
            check("bp_out_data", b_o_data, 32'h100 + 32'(k));
            tick();
        end
        check("bp_out_empty", 32'(b_o_valid), 32'd0);
        check("bp_ready_back", 32'(b_o_ready), 32'd1);
`ifdef PIPE_PAL_OCC_EN
        check("bp_count_zero", 32'(b_count), 32'd0);
`endif

        // ---- flush with 3 words held, simultaneous push and pop
        b_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("fl_fill_ready", 32'(b_o_ready), 32'd1);
            b_valid = 1'b1;
            b_data  = 32'h200 + 32'(k);
            tick();
        end
        check("fl_head_valid", 32'(b_o_valid), 32'd1);
        check("fl_head_data", b_o_data, 32'h200);
`ifdef PIPE_PAL_OCC_EN
        check("fl_count3", 32'(b_count), 32'd3);
`endif
        b_flush = 1'b1; b_valid = 1'b1; b_data = 32'hAA; b_ready = 1'b1;
        tick();
        b_flush = 1'b0; b_valid = 1'b0;
        check("fl_valid", 32'(b_o_valid), 32'd0);
        check("fl_ready", 32'(b_o_ready), 32'd1);
`ifdef PIPE_PAL_OCC_EN
        check("fl_count0", 32'(b_count), 32'd0);
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            check("fl_no_emit", 32'(b_o_valid), 32'd0);
        end

        // ---- random valid/ready with a queue scoreboard
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int c = 0; c < 3000; c++) begin
`ifdef PIPE_PAL_OCC_EN
            check("rnd_count", 32'(b_count), 32'(q.size()));
`endif
            if (prev_stall) begin
                check("rnd_hold_valid", 32'(b_o_valid), 32'd1);
                check("rnd_hold_data", b_o_data, prev_dat);
            end
            b_valid = 1'($urandom_range(0, 1));
            b_data  = $urandom;
            b_ready = 1'($urandom_range(0, 1));
            if (b_o_valid && b_ready) begin
                if (q.size() != 0) exp_w = q.pop_front();
                else exp_w = 'x;
                check("rnd_data", b_o_data, exp_w);
            end
            if (b_valid && b_o_ready) q.push_back(b_data);
            prev_stall = b_o_valid && !b_ready;
            prev_dat   = b_o_data;
            tick();
        end
        b_valid = 1'b0;
        b_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (b_o_valid) begin
                if (q.size() != 0) exp_w = q.pop_front();
                else exp_w = 'x;
                check("drn_data", b_o_data, exp_w);
            end
            tick();
        end
        check("drn_left", 32'(q.size()), 32'd0);
        check("drn_valid", 32'(b_o_valid), 32'd0);

        // ---- reset while words are held drops them
        b_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b_valid = 1'b1;
            b_data  = 32'h300 + 32'(k);
            tick();
        end
        b_valid = 1'b0;
        check("mrst_pre_valid", 32'(b_o_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_valid", 32'(b_o_valid), 32'd0);
        check("mrst_ready", 32'(b_o_ready), 32'd0);
        check("mrst_data", b_o_data, 32'd0);
        rst = 1'b0;
        b_ready = 1'b1;
        tick();
        check("mrst_ready_back", 32'(b_o_ready), 32'd1);
        tick();
        tick();
        check("mrst_no_emit", 32'(b_o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
